// File: rtl/halt_ctrl_pkg.sv
// halt_ctrl shared definitions: FSM states, the ebreak encoding, halt cause
// encodings and the exit code reported on a watchdog halt.
// Optional feature macro used by this slice: HALT_CTRL_TIMEOUT_EN.
package halt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REQ    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [31:0] EBREAK_INST   = 32'h0010_0073;
  localparam logic [31:0] TIMEOUT_CODE  = 32'hDEAD_0001;
  localparam logic [1:0]  CAUSE_EBREAK  = 2'd0;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'd1;

  function automatic logic is_ebreak(input logic [31:0] inst);
    return inst == EBREAK_INST;
  endfunction

endpackage

// File: rtl/halt_ctrl_if.sv
// Commit / halt handshake bundle between the core+simulation side (master)
// and halt_ctrl (slave). Clock and reset stay plain ports on the modules.
interface halt_ctrl_if;

  logic        commit_valid;
  logic [31:0] commit_inst;
  logic [63:0] commit_pc;
  logic [63:0] commit_a0;
  logic        stall;
  logic        halt_valid;
  logic [31:0] halt_code;
  logic [63:0] halt_pc;
  logic [1:0]  halt_cause;
  logic        halt_ack;
  logic [63:0] retired_cnt;
  logic [63:0] cycle_cnt;

  modport master (
    output commit_valid, commit_inst, commit_pc, commit_a0, halt_ack,
    input  stall, halt_valid, halt_code, halt_pc, halt_cause,
    input  retired_cnt, cycle_cnt
  );

  modport slave (
    input  commit_valid, commit_inst, commit_pc, commit_a0, halt_ack,
    output stall, halt_valid, halt_code, halt_pc, halt_cause,
    output retired_cnt, cycle_cnt
  );

endinterface

// File: rtl/halt_ctrl_perf_cnt64.sv
// perf_cnt64: free-running 64-bit counter with enable; the async active-low
// clear is the block reset. Wraps naturally modulo 2^64.
module perf_cnt64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] cnt
);

  logic [63:0] cnt_reg;

  // Count one per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 64'd1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/halt_ctrl.sv
// halt_ctrl: watches retired instructions for ebreak, freezes the core, waits
// a fixed drain period, then raises a halt request that stays up until the
// simulation side acknowledges it. HALTED is terminal until reset.
// Define HALT_CTRL_TIMEOUT_EN to add a no-retire watchdog that halts with
// cause 1 and code 32'hDEAD_0001.
module halt_ctrl
  import halt_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  halt_ctrl_if.slave  bus
);

  // Last drain count value before moving to REQ (unused when DRAIN_CYCLES=0).
  localparam logic [3:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  state_e      state_reg, state_next;
  logic [3:0]  drain_cnt_reg, drain_cnt_next;
  logic        stall_reg, stall_next;
  logic        valid_reg, valid_next;
  logic [31:0] code_reg, code_next;
  logic [63:0] pc_reg, pc_next;
  logic [1:0]  cause_reg, cause_next;

  logic in_run;
  logic commit_in_run;
  logic ebreak_hit;
  logic timeout_hit;

  assign in_run        = (state_reg == ST_RUN);
  assign commit_in_run = in_run && bus.commit_valid;
  assign ebreak_hit    = commit_in_run && is_ebreak(bus.commit_inst);

`ifdef HALT_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_reg;
  logic [63:0]     last_pc_reg;

  // Expiry happens on the cycle that would make the idle count reach the limit;
  // a commit in that cycle clears the watchdog instead, so ebreak always wins.
  assign timeout_hit = in_run && !bus.commit_valid && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: idle RUN cycles since the last retire, plus the last retired PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_reg      <= '0;
      last_pc_reg <= '0;
    end else if (in_run) begin
      if (bus.commit_valid) begin
        wd_reg      <= '0;
        last_pc_reg <= bus.commit_pc;
      end else if (!timeout_hit) begin
        wd_reg <= wd_reg + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register plus drain counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // Next-state logic: RUN -> DRAIN (or straight to REQ) -> REQ -> HALTED.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (ebreak_hit || timeout_hit) begin
          drain_cnt_next = '0;
          state_next     = (DRAIN_CYCLES == 0) ? ST_REQ : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = ST_REQ;
        end else begin
          drain_cnt_next = drain_cnt_reg + 4'd1;
        end
      end
      ST_REQ: begin
        if (bus.halt_ack) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Output logic: derive next registered outputs from the upcoming state so
  // stall/halt_valid change on the same edge as the state does.
  always_comb begin
    stall_next = (state_next != ST_RUN);
    valid_next = (state_next == ST_REQ);
    code_next  = code_reg;
    pc_next    = pc_reg;
    cause_next = cause_reg;
    if (ebreak_hit) begin
      code_next  = bus.commit_a0[31:0];
      pc_next    = bus.commit_pc;
      cause_next = CAUSE_EBREAK;
    end
`ifdef HALT_CTRL_TIMEOUT_EN
    else if (timeout_hit) begin
      code_next  = TIMEOUT_CODE;
      pc_next    = last_pc_reg;
      cause_next = CAUSE_TIMEOUT;
    end
`endif
  end

  // Output registers: no input reaches an output combinationally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_reg <= 1'b0;
      valid_reg <= 1'b0;
      code_reg  <= '0;
      pc_reg    <= '0;
      cause_reg <= CAUSE_EBREAK;
    end else begin
      stall_reg <= stall_next;
      valid_reg <= valid_next;
      code_reg  <= code_next;
      pc_reg    <= pc_next;
      cause_reg <= cause_next;
    end
  end

  assign bus.stall      = stall_reg;
  assign bus.halt_valid = valid_reg;
  assign bus.halt_code  = code_reg;
  assign bus.halt_pc    = pc_reg;
  assign bus.halt_cause = cause_reg;

  perf_cnt64 u_retired_cnt (
    .clk   (clock),
    .rst_n (reset),
    .en    (commit_in_run),
    .cnt   (bus.retired_cnt)
  );

  perf_cnt64 u_cycle_cnt (
    .clk   (clock),
    .rst_n (reset),
    .en    (state_reg != ST_HALTED),
    .cnt   (bus.cycle_cnt)
  );

endmodule
